// File: rtl/gb_ppu_pkg.sv
// Shared Game Boy PPU definitions: mode encoding, LCD geometry, framebuffer sizing.
// The row_base helper forms y*40 with shifts and adds rather than a multiply.
package gb_ppu_pkg;

   typedef enum logic [1:0] {
      H_BLANK = 2'd0,
      V_BLANK = 2'd1,
      SCAN    = 2'd2,
      DRAW    = 2'd3
   } ppu_mode_e;

   localparam int unsigned LCD_W    = 160;
   localparam int unsigned LCD_H    = 144;
   localparam int unsigned FB_BYTES = 5760;
   localparam int unsigned ADDR_W   = 13;
   localparam int unsigned DATA_W   = 8;

   // Byte offset of a framebuffer row: 40 packed bytes per line.
   function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
      logic [ADDR_W-1:0] yw;
      yw = {5'b0, y};
      return (yw << 5) + (yw << 3);
   endfunction

endpackage

// File: rtl/gb_sync_fifo.sv
// Synchronous FIFO with a wrap bit on each pointer; a push while full or a pop
// while empty is ignored. Storage is not reset; only the pointers are.
module gb_sync_fifo #(
   parameter int unsigned WIDTH = 21,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty   = (wptr == rptr);
      full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      do_push = push && !full;
      do_pop  = pop && !empty;
      head    = mem[rptr[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rptr <= rptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/gb_lcd_sink.sv
// PPU pixel sink: palette-maps 2-bit pixels, packs four per byte and queues
// {address, byte} writes to the framebuffer behind a ready/valid port.
module gb_lcd_sink
   import gb_ppu_pkg::*;
#(
   parameter int unsigned H_PIXELS   = LCD_W,
   parameter int unsigned V_LINES    = LCD_H,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lcd_en,
   input  logic [1:0]        ppu_mode,
   input  logic [1:0]        px_in,
   input  logic              px_valid,
   input  logic [7:0]        bgp,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_data,
   output logic              fb_wr,
   input  logic              fb_ready,
   output logic              frame_done,
   output logic              overflow
);

   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
   localparam logic [7:0]  X_END   = 8'(H_PIXELS);
   localparam logic [7:0]  Y_END   = 8'(V_LINES);

   ppu_mode_e           mode;
   ppu_mode_e           prev_mode;
   logic [7:0]          x;
   logic [7:0]          y;
   logic [7:0]          pack;
   logic [1:0]          cnt;

   logic                px_live;
   logic                accept;
   logic                px_drop;
   logic [1:0]          shade;
   logic [7:0]          pack_nx;
   logic [1:0]          cnt_nx;
   logic                group_done;
   logic                line_end;
   logic                vb_entry;
   logic                frame_end;
   logic [7:0]          y_inc;
   logic                push;
   logic [DATA_W-1:0]   push_byte;
   logic [ADDR_W-1:0]   push_addr;

   logic                fifo_full;
   logic                fifo_empty;
   logic [ENTRY_W-1:0]  fifo_head;

   always_comb begin
      mode       = ppu_mode_e'(ppu_mode);
      px_live    = px_valid && lcd_en;
      accept     = px_live && (x < X_END);
      px_drop    = px_live && !(x < X_END);
      shade      = bgp[{px_in, 1'b0} +: 2];
      pack_nx    = accept ? {pack[5:0], shade} : pack;
      cnt_nx     = cnt + {1'b0, accept};
      group_done = accept && (cnt == 2'd3);
      line_end   = lcd_en && (prev_mode == DRAW) && (mode == H_BLANK);
      vb_entry   = (prev_mode != V_BLANK) && (mode == V_BLANK);
      y_inc      = y + 8'd1;
      frame_end  = lcd_en && ((line_end && (y_inc == Y_END)) || (vb_entry && (y != 8'd0)));
      // A flush coinciding with a completed group leaves cnt_nx at 0, so it
      // collapses into the single group push.
      push       = group_done || (line_end && (cnt_nx != 2'd0));
      // x still indexes the current group here: it is 4k+cnt before increment.
      push_addr  = row_base(y) + {5'b0, 2'b0, x[7:2]};
      case (cnt_nx)
         2'd1:    push_byte = {pack_nx[1:0], 6'b0};
         2'd2:    push_byte = {pack_nx[3:0], 4'b0};
         2'd3:    push_byte = {pack_nx[5:0], 2'b0};
         default: push_byte = pack_nx;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_mode  <= H_BLANK;
         x          <= '0;
         y          <= '0;
         pack       <= '0;
         cnt        <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         prev_mode <= mode;
         if (px_drop || (push && fifo_full)) begin
            overflow <= 1'b1;
         end
         if (!lcd_en) begin
            x          <= '0;
            y          <= '0;
            pack       <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
         end else begin
            frame_done <= frame_end;
            if (line_end) begin
               x    <= '0;
               cnt  <= '0;
               pack <= '0;
               y    <= frame_end ? 8'd0 : y_inc;
            end else begin
               x    <= x + {7'b0, accept};
               cnt  <= cnt_nx;
               pack <= pack_nx;
               if (frame_end) begin
                  y <= '0;
               end
            end
         end
      end
   end

   gb_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({push_addr, push_byte}),
      .pop       (fb_wr && fb_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Head is masked while empty so the write port reads as zero out of reset.
   always_comb begin
      fb_wr   = !fifo_empty;
      fb_addr = fifo_empty ? '0 : fifo_head[ENTRY_W-1:DATA_W];
      fb_data = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
   end

endmodule

// File: tb/tb_gb_lcd_sink.sv
// Directed bench for gb_lcd_sink: a behavioural pixel/line model queues the
// expected framebuffer writes, and a negedge monitor pops and compares them.
module tb_gb_lcd_sink;
   import gb_ppu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        lcd_en;
   logic [1:0]  ppu_mode;
   logic [1:0]  px_in;
   logic        px_valid;
   logic [7:0]  bgp;
   logic [12:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_wr;
   logic        fb_ready;
   logic        frame_done;
   logic        overflow;

   int vectors    = 0;
   int miscompares = 0;
   int writes     = 0;
   int frame_cnt  = 0;
   int last_addr  = -1;

   logic [20:0] exp_q[$];
   int          mx, my, mcnt, room, frames_exp;
   logic [7:0]  mpack;
   logic        ovf_exp;

   gb_lcd_sink #(
      .H_PIXELS   (160),
      .V_LINES    (144),
      .FIFO_DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .lcd_en     (lcd_en),
      .ppu_mode   (ppu_mode),
      .px_in      (px_in),
      .px_valid   (px_valid),
      .bgp        (bgp),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_wr      (fb_wr),
      .fb_ready   (fb_ready),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [20:0] e;
      if (!rst) begin
         if (frame_done) frame_cnt++;
         if (fb_wr && fb_ready) begin
            writes++;
            vectors++;
            assert (exp_q.size() != 0) else begin
               miscompares++;
               $error("FAIL unexpected_write observed=%0d/%h expected=none", fb_addr, fb_data);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               vectors++;
               assert ({fb_addr, fb_data} === e) else begin
                  miscompares++;
                  $error("FAIL fb_write observed=%0d/%h expected=%0d/%h", fb_addr, fb_data, e[20:8], e[7:0]);
               end
               last_addr = int'(fb_addr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int addr, input logic [7:0] data);
      if (room == 0) begin
         ovf_exp = 1'b1;
      end else begin
         exp_q.push_back({13'(addr), data});
         if (room > 0) room--;
      end
   endtask

   task automatic model_reset();
      mx = 0; my = 0; mcnt = 0; mpack = 8'h00;
   endtask

   task automatic send_px(input logic [1:0] p);
      logic [7:0] sh;
      px_in = p;
      px_valid = 1'b1;
      if (mx < 160) begin
         sh = (bgp >> (2 * p)) & 8'h03;
         mpack = (mpack << 2) | sh;
         mcnt++;
         if (mcnt == 4) begin
            push_exp(my * 40 + mx / 4, mpack);
            mcnt = 0;
            mpack = 8'h00;
         end
         mx++;
      end else begin
         ovf_exp = 1'b1;
      end
      tick();
      px_valid = 1'b0;
   endtask

   task automatic line_end();
      ppu_mode = H_BLANK;
      if (mcnt != 0) push_exp(my * 40 + mx / 4, mpack << (2 * (4 - mcnt)));
      mx = 0; mcnt = 0; mpack = 8'h00;
      my++;
      if (my == 144) begin
         my = 0;
         frames_exp++;
      end
      tick();
      ppu_mode = DRAW;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
      tick();
      tick();
      check({tag, "_drain"}, exp_q.size(), 0);
   endtask

   initial begin
      int base;
      rst = 1'b1; lcd_en = 1'b1; ppu_mode = DRAW; px_in = 2'd0; px_valid = 1'b0;
      bgp = 8'hE4; fb_ready = 1'b1;
      room = -1; frames_exp = 0; ovf_exp = 1'b0;
      model_reset();
      repeat (3) tick();
      check("rst_fb_wr", fb_wr, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_data", fb_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b0;
      tick();

      // 3,2,1,0 through the identity palette -> 0xE4 at address 0, one cycle later
      send_px(2'd3); send_px(2'd2); send_px(2'd1);
      check("lat_before", fb_wr, 0);
      send_px(2'd0);
      check("lat_fb_wr", fb_wr, 1);
      check("lat_addr", fb_addr, 0);
      check("lat_data", fb_data, 8'hE4);
      drain("t1");
      line_end();

      // Advance to y=5, then x=8 with bgp=0x1B -> 0xFF at 202
      repeat (4) begin
         tick();
         line_end();
      end
      repeat (8) send_px(2'd0);
      bgp = 8'h1B;
      repeat (4) send_px(2'd0);
      drain("t2");
      check("t2_last_addr", last_addr, 202);
      line_end();

      // V_BLANK entry with y != 0 ends the frame
      base = frame_cnt;
      ppu_mode = V_BLANK;
      my = 0; frames_exp++;
      tick();
      check("vb_pulse", frame_done, 1);
      tick();
      check("vb_pulse_end", frame_done, 0);
      ppu_mode = DRAW;
      tick();
      check("vb_count", frame_cnt, base + 1);

      // Partial flush: 6 pixels -> 0x55 @0, 0x50 @1; next line at y=1
      bgp = 8'hE4;
      repeat (6) send_px(2'd1);
      line_end();
      repeat (4) send_px(2'd2);
      drain("t3");
      check("t3_next_line", last_addr, 40);
      line_end();

      // lcd_en low clears position and the partial group
      send_px(2'd3); send_px(2'd3);
      lcd_en = 1'b0;
      model_reset();
      tick();
      lcd_en = 1'b1;
      repeat (4) send_px(2'd1);
      drain("lcd_en");
      check("lcd_en_addr", last_addr, 0);
      line_end();

      // 161 pixels: the last is dropped and flags overflow
      base = writes;
      for (int i = 0; i < 160; i++) send_px(2'($urandom_range(3, 0)));
      tick();
      check("ovf_160", overflow, 0);
      send_px(2'd3);
      check("ovf_161", overflow, 1);
      drain("px161");
      check("px161_writes", writes - base, 40);
      line_end();

      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      ovf_exp = 1'b0;
      check("rst2_overflow", overflow, 0);

      // Stall: 40 bytes produced, FIFO keeps the first 8
      fb_ready = 1'b0;
      room = 8;
      base = writes;
      for (int i = 0; i < 160; i++) send_px(2'($urandom_range(3, 0)));
      tick();
      check("stall_fb_wr", fb_wr, 1);
      check("stall_head_addr", fb_addr, int'(exp_q[0][20:8]));
      repeat (3) tick();
      check("stall_head_stable", {fb_addr, fb_data}, int'(exp_q[0]));
      check("stall_overflow", overflow, int'(ovf_exp));
      line_end();
      room = -1;
      fb_ready = 1'b1;
      drain("stall");
      check("stall_writes", writes - base, 8);

      // Full frame of 144 lines
      ppu_mode = V_BLANK;
      my = 0; frames_exp++;
      tick();
      ppu_mode = DRAW;
      tick();
      base = frame_cnt;
      for (int l = 0; l < 144; l++) begin
         bgp = 8'($urandom);
         for (int p = 0; p < 160; p++) send_px(2'($urandom_range(3, 0)));
         if (l == 143) check("frame_none_early", frame_cnt, base);
         line_end();
      end
      tick();
      tick();
      check("frame_once", frame_cnt, base + 1);
      drain("frame");
      check("frame_last_addr", last_addr, 5759);
      check("frame_total", frame_cnt, frames_exp);
      repeat (4) send_px(2'd2);
      drain("frame_wrap");
      check("frame_y0", last_addr, 0);

      // rst mid-write drops FIFO contents
      fb_ready = 1'b0;
      repeat (12) send_px(2'd1);
      tick();
      check("midrst_pre_wr", fb_wr, 1);
      rst = 1'b1;
      tick();
      exp_q.delete();
      model_reset();
      check("midrst_fb_wr", fb_wr, 0);
      check("midrst_addr", fb_addr, 0);
      check("midrst_data", fb_data, 0);
      check("midrst_frame_done", frame_done, 0);
      check("midrst_overflow", overflow, 0);
      rst = 1'b0;
      fb_ready = 1'b1;
      base = writes;
      repeat (4) tick();
      check("midrst_empty", fb_wr, 0);
      check("midrst_no_writes", writes - base, 0);
      check("final_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
